// File: rtl/fb_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : fb_bus_bridge
// Description : Sole master of the frame-buffer control FSM's 16-bit request
//               port. After reset it clears INIT_LINES x 1024 pixels, drawing
//               a BORDER_COLOR frame around FILL_COLOR. Once the clear is
//               complete it splits each 32-bit CPU access into two 16-bit
//               pixel accesses (even pixel first, then odd pixel).
// Ports       : pclk, rst          - clock, synchronous active-high reset
//               cpu_stb/we/addr    - CPU request (word address, two pixels)
//               cpu_data_in/out    - {odd pixel, even pixel}
//               cpu_ack            - one-cycle completion pulse
//               fb_stb/we/addr     - registered pixel request, addr {y,x}
//               fb_data_wr/rd      - pixel write / read data
//               fb_ack             - one-cycle completion from frame buffer
//               init_done          - clear finished, CPU accesses accepted
// Revision    : 1.0 - initial release
// ============================================================================
module fb_bus_bridge #(
  parameter int          INIT_LINES   = 768,
  parameter logic [15:0] BORDER_COLOR = 16'h739C,
  parameter logic [15:0] FILL_COLOR   = 16'h0000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out,
  output logic        cpu_ack,
  output logic        fb_stb,
  output logic        fb_we,
  output logic [19:0] fb_addr,
  output logic [15:0] fb_data_wr,
  input  logic [15:0] fb_data_rd,
  input  logic        fb_ack,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_INIT_WR  = 3'd0,
    S_INIT_INC = 3'd1,
    S_IDLE     = 3'd2,
    S_LO       = 3'd3,
    S_GAP1     = 3'd4,
    S_HI       = 3'd5,
    S_ACK      = 3'd6
  } state_t;

  localparam logic [19:0] C_LAST_ADDR = 20'(INIT_LINES * 1024 - 1);
  localparam logic [9:0]  C_LAST_Y    = 10'(INIT_LINES - 1);

  // Border test on the 10-bit x and y fields of a pixel address.
  function automatic logic [15:0] init_pixel(input logic [19:0] a);
    if (a[9:0] == 10'd0 || a[9:0] == 10'd1023 ||
        a[19:10] == 10'd0 || a[19:10] == C_LAST_Y) begin
      return BORDER_COLOR;
    end
    return FILL_COLOR;
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] rd_lo_q, rd_lo_d;
  logic [31:0] cpu_data_out_q, cpu_data_out_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        init_done_q, init_done_d;
  logic        fb_stb_q, fb_stb_d;
  logic        fb_we_q, fb_we_d;
  logic [19:0] fb_addr_q, fb_addr_d;
  logic [15:0] fb_data_wr_q, fb_data_wr_d;

  // An ack only completes an access while a request is actually outstanding.
  logic fb_done;
  assign fb_done = fb_stb_q & fb_ack;

  // Request outputs are computed for the state being entered, so the
  // request is already on the port in the first cycle of LO / HI / INIT_WR.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_lo_d        = rd_lo_q;
    cpu_data_out_d = cpu_data_out_q;
    cpu_ack_d      = 1'b0;
    init_done_d    = init_done_q;
    fb_stb_d       = fb_stb_q;
    fb_we_d        = fb_we_q;
    fb_addr_d      = fb_addr_q;
    fb_data_wr_d   = fb_data_wr_q;

    case (state_q)
      S_INIT_WR: begin
        // Straight after reset fb_stb is still low here; raise it now.
        fb_stb_d     = 1'b1;
        fb_we_d      = 1'b1;
        fb_addr_d    = cnt_q;
        fb_data_wr_d = init_pixel(cnt_q);
        if (fb_done) begin
          fb_stb_d = 1'b0;
          state_d  = S_INIT_INC;
        end
      end

      S_INIT_INC: begin
        if (cnt_q == C_LAST_ADDR) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d        = cnt_q + 20'd1;
          fb_stb_d     = 1'b1;
          fb_we_d      = 1'b1;
          fb_addr_d    = cnt_q + 20'd1;
          fb_data_wr_d = init_pixel(cnt_q + 20'd1);
          state_d      = S_INIT_WR;
        end
      end

      S_IDLE: begin
        if (cpu_stb && init_done_q) begin
          we_d         = cpu_we;
          addr_d       = cpu_addr;
          wdata_d      = cpu_data_in;
          fb_stb_d     = 1'b1;
          fb_we_d      = cpu_we;
          fb_addr_d    = {cpu_addr, 1'b0};
          fb_data_wr_d = cpu_data_in[15:0];
          state_d      = S_LO;
        end
      end

      S_LO: begin
        if (fb_done) begin
          if (!we_q) begin
            rd_lo_d = fb_data_rd;
          end
          fb_stb_d = 1'b0;
          state_d  = S_GAP1;
        end
      end

      S_GAP1: begin
        fb_stb_d     = 1'b1;
        fb_we_d      = we_q;
        fb_addr_d    = {addr_q, 1'b1};
        fb_data_wr_d = wdata_q[31:16];
        state_d      = S_HI;
      end

      S_HI: begin
        if (fb_done) begin
          // The odd pixel goes straight into the output register, so no
          // separate holding register is needed for it.
          if (!we_q) begin
            cpu_data_out_d = {fb_data_rd, rd_lo_q};
          end
          fb_stb_d  = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = S_ACK;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT_WR;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= S_INIT_WR;
      cnt_q          <= 20'd0;
      we_q           <= 1'b0;
      addr_q         <= 19'd0;
      wdata_q        <= 32'd0;
      rd_lo_q        <= 16'd0;
      cpu_data_out_q <= 32'd0;
      cpu_ack_q      <= 1'b0;
      init_done_q    <= 1'b0;
      fb_stb_q       <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= 20'd0;
      fb_data_wr_q   <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_lo_q        <= rd_lo_d;
      cpu_data_out_q <= cpu_data_out_d;
      cpu_ack_q      <= cpu_ack_d;
      init_done_q    <= init_done_d;
      fb_stb_q       <= fb_stb_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_data_wr_q   <= fb_data_wr_d;
    end
  end

  assign cpu_data_out = cpu_data_out_q;
  assign cpu_ack      = cpu_ack_q;
  assign init_done    = init_done_q;
  assign fb_stb       = fb_stb_q;
  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data_wr   = fb_data_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_bus_bridge
// Description : Directed self-checking bench for fb_bus_bridge, with a small
//               frame-buffer model (programmable ack delay) and access log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_bus_bridge;

  localparam int LINES = 4;
  localparam int NPIX  = LINES * 1024;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_stb = 1'b0;
  logic        cpu_we = 1'b0;
  logic [18:0] cpu_addr = 19'd0;
  logic [31:0] cpu_data_in = 32'd0;
  logic [31:0] cpu_data_out;
  logic        cpu_ack;
  logic        fb_stb;
  logic        fb_we;
  logic [19:0] fb_addr;
  logic [15:0] fb_data_wr;
  logic [15:0] fb_data_rd = 16'd0;
  logic        fb_ack = 1'b0;
  logic        init_done;

  fb_bus_bridge #(
    .INIT_LINES  (LINES),
    .BORDER_COLOR(16'h739C),
    .FILL_COLOR  (16'h0000)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .cpu_stb     (cpu_stb),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_data_in (cpu_data_in),
    .cpu_data_out(cpu_data_out),
    .cpu_ack     (cpu_ack),
    .fb_stb      (fb_stb),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data_wr  (fb_data_wr),
    .fb_data_rd  (fb_data_rd),
    .fb_ack      (fb_ack),
    .init_done   (init_done)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- frame-buffer model and monitor ----------------
  int          ack_dly = 4;
  int          mcnt = 0;
  logic [36:0] log_q[$];
  int          init_idx = 0;
  int          seq_err = 0;
  bit          cap_init = 1'b1;
  logic [15:0] d_0 = 16'hxxxx, d_1025 = 16'hxxxx, d_3ff = 16'hxxxx;
  logic [15:0] d_last5 = 16'hxxxx, d_2047 = 16'hxxxx;
  int          ack_pulses = 0;
  int          early_acks = 0;
  int          done_at = -1;
  logic        prev_done = 1'b0;

  function automatic logic [15:0] rd_val(input logic [19:0] a);
    if (a == 20'h00400) return 16'h1234;
    if (a == 20'h00401) return 16'hABCD;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [36:0] get_log(input int i);
    if (i < log_q.size()) return log_q[i];
    return 37'h0;
  endfunction

  always @(negedge pclk) begin
    if (cpu_ack) begin
      ack_pulses++;
      if (!init_done) early_acks++;
    end
    if (init_done && !prev_done) done_at = log_q.size();
    prev_done = init_done;

    if (rst || !fb_stb) begin
      fb_ack = 1'b0;
      mcnt   = 0;
    end else if (fb_ack) begin
      fb_ack = 1'b0;
    end else begin
      mcnt++;
      if (mcnt >= ack_dly) begin
        mcnt       = 0;
        fb_ack     = 1'b1;
        fb_data_rd = rd_val(fb_addr);
        log_q.push_back({fb_we, fb_addr, fb_data_wr});
        if (cap_init && !init_done) begin
          if (fb_addr != 20'(init_idx) || !fb_we) seq_err++;
          init_idx++;
          case (fb_addr)
            20'h00000: d_0     = fb_data_wr;
            20'h00401: d_1025  = fb_data_wr;
            20'h003FF: d_3ff   = fb_data_wr;
            20'h007FF: d_2047  = fb_data_wr;
            20'h00C05: d_last5 = fb_data_wr;
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      @(posedge pclk);
      #1;
      n++;
    end while (!cpu_ack && n < budget);
    check("ack_seen", 64'(cpu_ack), 64'd1);
  endtask

  initial begin
    int n;
    int base;
    int p0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_fb_stb", 64'(fb_stb), 64'd0);
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_cpu_data_out", 64'(cpu_data_out), 64'd0);
    check("rst_fb_addr", 64'(fb_addr), 64'd0);
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_fb_data_wr", 64'(fb_data_wr), 64'd0);

    // Clear with a CPU write pending throughout
    rst         = 1'b0;
    cpu_stb     = 1'b1;
    cpu_we      = 1'b1;
    cpu_addr    = 19'd0;
    cpu_data_in = 32'hAAAA5555;
    wait_ack(40000, n);
    check("init_done_at_ack", 64'(init_done), 64'd1);
    check("no_ack_during_init", 64'(early_acks), 64'd0);
    check("done_after_last_init", 64'(done_at), 64'(NPIX));
    check("init_write_count", 64'(init_idx), 64'(NPIX));
    check("init_order", 64'(seq_err), 64'd0);
    check("pix_0", 64'(d_0), 64'h739C);
    check("pix_1025", 64'(d_1025), 64'h0000);
    check("pix_3ff", 64'(d_3ff), 64'h739C);
    check("pix_7ff", 64'(d_2047), 64'h739C);
    check("pix_last_line_x5", 64'(d_last5), 64'h739C);
    check("log_after_init_wr", 64'(log_q.size()), 64'(NPIX + 2));
    check("wr_lo", 64'(get_log(NPIX)), 64'({1'b1, 20'd0, 16'h5555}));
    check("wr_hi", 64'(get_log(NPIX + 1)), 64'({1'b1, 20'd1, 16'hAAAA}));
    cpu_stb = 1'b0;
    @(posedge pclk);
    #1;
    check("ack_one_cycle", 64'(cpu_ack), 64'd0);
    repeat (20) @(posedge pclk);
    #1;
    check("no_extra_fb_access", 64'(log_q.size()), 64'(NPIX + 2));
    check("fb_stb_idle", 64'(fb_stb), 64'd0);

    // Read, 4-cycle frame-buffer ack
    base     = log_q.size();
    cpu_we   = 1'b0;
    cpu_addr = 19'h00200;
    cpu_stb  = 1'b1;
    wait_ack(100, n);
    check("rd_latency", 64'(n + 1), 64'd11);
    check("rd_data", 64'(cpu_data_out), 64'hABCD1234);
    check("rd_lo_access", 64'(get_log(base) >> 16), 64'({1'b0, 20'h00400}));
    check("rd_hi_access", 64'(get_log(base + 1) >> 16), 64'({1'b0, 20'h00401}));
    cpu_stb = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rd_data_held", 64'(cpu_data_out), 64'hABCD1234);

    // Same-cycle frame-buffer ack
    ack_dly     = 1;
    base        = log_q.size();
    cpu_we      = 1'b1;
    cpu_addr    = 19'd5;
    cpu_data_in = 32'h0BADF00D;
    cpu_stb     = 1'b1;
    wait_ack(100, n);
    check("fast_latency", 64'(n + 1), 64'd5);
    check("fast_lo", 64'(get_log(base)), 64'({1'b1, 20'd10, 16'hF00D}));
    check("fast_hi", 64'(get_log(base + 1)), 64'({1'b1, 20'd11, 16'h0BAD}));

    // Back-to-back writes: new request already up in the IDLE cycle
    cpu_stb = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    base        = log_q.size();
    p0          = ack_pulses;
    cpu_addr    = 19'h10;
    cpu_data_in = 32'h11112222;
    cpu_stb     = 1'b1;
    wait_ack(100, n);
    cpu_addr    = 19'h11;
    cpu_data_in = 32'h33334444;
    wait_ack(100, n);
    cpu_stb = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("b2b_access_count", 64'(log_q.size() - base), 64'd4);
    check("b2b_ack_count", 64'(ack_pulses - p0), 64'd2);
    check("b2b_0", 64'(get_log(base)), 64'({1'b1, 20'h20, 16'h2222}));
    check("b2b_1", 64'(get_log(base + 1)), 64'({1'b1, 20'h21, 16'h1111}));
    check("b2b_2", 64'(get_log(base + 2)), 64'({1'b1, 20'h22, 16'h4444}));
    check("b2b_3", 64'(get_log(base + 3)), 64'({1'b1, 20'h23, 16'h3333}));
    check("rd_data_kept_over_writes", 64'(cpu_data_out), 64'hABCD1234);

    // Reset in HI with fb_stb high
    ack_dly  = 4;
    cap_init = 1'b0;
    base     = log_q.size();
    cpu_we   = 1'b0;
    cpu_addr = 19'h20;
    cpu_stb  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge pclk);
      #1;
      if (log_q.size() == base + 1 && fb_stb) break;
    end
    check("hi_stb_before_rst", 64'(fb_stb), 64'd1);
    check("hi_addr_before_rst", 64'(fb_addr), 64'h41);
    rst     = 1'b1;
    cpu_stb = 1'b0;
    @(posedge pclk);
    #1;
    check("midrst_fb_stb", 64'(fb_stb), 64'd0);
    check("midrst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("midrst_init_done", 64'(init_done), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk);
      #1;
      if (fb_stb) break;
    end
    check("restart_stb", 64'(fb_stb), 64'd1);
    check("restart_addr", 64'(fb_addr), 64'd0);
    check("restart_we", 64'(fb_we), 64'd1);
    check("restart_data", 64'(fb_data_wr), 64'h739C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
